// File: rtl/image_stage_sequencer.sv
// ---------------------------------------------------------------------------
// image_stage_sequencer
//
// Runs the image-processing engines one at a time, lowest index first, through
// their enable/done handshakes, and routes the single SRAM port to whichever
// engine is currently running.
//
// Optional feature: define IMAGE_STAGE_SEQUENCER_TIMEOUT_EN to add a per-stage
// watchdog. A stage that stays in RUN for TIMEOUT_CYCLES un-paused cycles is
// released as if it had signalled done, and its timeout_status bit is set.
// Without the macro there is no watchdog and timeout_status is tied to 0.
//
// Ports
//   clk, reset_n      : clock, synchronous active-low reset
//   start, stage_mask : one-cycle run request and the set of stages to run
//   abort             : cancel the sequence in progress (overrides pause)
//   pause             : freeze FSM, mask, current stage and watchdog
//   stage_enable      : per-engine enable, at most one bit high (RUN only)
//   stage_done        : per-engine done; only the active stage's bit is used
//   stage_wren/_address/_data_write : per-engine SRAM requests, stage i at
//                       [i*W +: W]
//   mem_wren/_address/_data_write   : SRAM port, active engine in RUN else 0
//   busy              : sequence in progress (SELECT/RUN/RELEASE)
//   sequence_done     : one-cycle pulse while in DONE
//   current_stage     : index of the engine being run or selected
//   timeout_status    : sticky per-stage watchdog flags
// ---------------------------------------------------------------------------
module image_stage_sequencer #(
    parameter int unsigned NUM_STAGES     = 4,
    parameter int unsigned ADDR_W         = 18,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned IDX_W          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 262143
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [NUM_STAGES-1:0]        stage_mask,
    input  logic                         abort,
    input  logic                         pause,
    output logic [NUM_STAGES-1:0]        stage_enable,
    input  logic [NUM_STAGES-1:0]        stage_done,
    input  logic [NUM_STAGES-1:0]        stage_wren,
    input  logic [NUM_STAGES*ADDR_W-1:0] stage_address,
    input  logic [NUM_STAGES*DATA_W-1:0] stage_data_write,
    output logic                         mem_wren,
    output logic [ADDR_W-1:0]            mem_address,
    output logic [DATA_W-1:0]            mem_data_write,
    output logic                         busy,
    output logic                         sequence_done,
    output logic [IDX_W-1:0]             current_stage,
    output logic [NUM_STAGES-1:0]        timeout_status
);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        RUN,
        RELEASE,
        DONE
    } state_t;

    state_t                state, next_state;
    logic [NUM_STAGES-1:0] mask_q;
    logic [IDX_W-1:0]      cur_q;
    logic [IDX_W-1:0]      low_idx;
    logic                  low_found;
    logic                  active_done;
    logic                  wd_hit;
    logic                  stage_finish;

    // Lowest set bit of the latched mask picks the next stage.
    always_comb begin
        low_idx   = '0;
        low_found = 1'b0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (mask_q[i] && !low_found) begin
                low_idx   = IDX_W'(i);
                low_found = 1'b1;
            end
        end
    end

    assign active_done  = stage_done[cur_q];
    assign stage_finish = (state == RUN) && (active_done || wd_hit);

`ifdef IMAGE_STAGE_SEQUENCER_TIMEOUT_EN
    localparam logic [ADDR_W-1:0] WD_LAST = ADDR_W'(TIMEOUT_CYCLES - 1);

    logic [ADDR_W-1:0] wd_cnt;

    // Counter holds the number of un-paused RUN cycles already spent, so the
    // edge ending the TIMEOUT_CYCLES-th cycle sees WD_LAST.
    assign wd_hit = (state == RUN) && (wd_cnt == WD_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wd_cnt <= '0;
        end else if (state != RUN) begin
            wd_cnt <= '0;
        end else if (!pause) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timeout_status <= '0;
        end else if (!pause && !abort) begin
            if (state == IDLE && start) begin
                timeout_status <= '0;
            end else if (state == RUN && wd_hit && !active_done) begin
                // A real done on the same edge wins: no flag in that case.
                timeout_status[cur_q] <= 1'b1;
            end
        end
    end
`else
    assign wd_hit         = 1'b0;
    assign timeout_status = '0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: abort beats pause, pause beats everything else.
    always_comb begin
        next_state = state;
        if (abort && state != IDLE) begin
            next_state = IDLE;
        end else if (!pause) begin
            case (state)
                IDLE:    if (start) next_state = (stage_mask != '0) ? SELECT : DONE;
                SELECT:  next_state = low_found ? RUN : DONE;
                RUN:     if (active_done || wd_hit) next_state = RELEASE;
                RELEASE: next_state = SELECT;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Latched mask and current stage index
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mask_q <= '0;
            cur_q  <= '0;
        end else if (abort && state != IDLE) begin
            mask_q <= '0;
        end else if (!pause) begin
            if (state == IDLE && start) begin
                mask_q <= stage_mask;
            end else if (state == SELECT && low_found) begin
                cur_q <= low_idx;
            end else if (stage_finish) begin
                mask_q[cur_q] <= 1'b0;
            end
        end
    end

    // Outputs decoded from state
    always_comb begin
        stage_enable   = '0;
        mem_wren       = 1'b0;
        mem_address    = '0;
        mem_data_write = '0;
        if (state == RUN) begin
            stage_enable[cur_q] = 1'b1;
            mem_wren            = stage_wren[cur_q];
            mem_address         = stage_address[int'(cur_q)*ADDR_W +: ADDR_W];
            mem_data_write      = stage_data_write[int'(cur_q)*DATA_W +: DATA_W];
        end
        busy          = (state == SELECT) || (state == RUN) || (state == RELEASE);
        sequence_done = (state == DONE);
        current_stage = cur_q;
    end

endmodule

// File: tb/tb_image_stage_sequencer.sv
module tb_image_stage_sequencer;

  localparam int unsigned NS = 4;
  localparam int unsigned AW = 18;
  localparam int unsigned DW = 32;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [NS-1:0]    stage_mask;
  logic             abort;
  logic             pause;
  logic [NS-1:0]    stage_enable;
  logic [NS-1:0]    stage_done;
  logic [NS-1:0]    stage_wren;
  logic [NS*AW-1:0] stage_address;
  logic [NS*DW-1:0] stage_data_write;
  logic             mem_wren;
  logic [AW-1:0]    mem_address;
  logic [DW-1:0]    mem_data_write;
  logic             busy;
  logic             sequence_done;
  logic [1:0]       current_stage;
  logic [NS-1:0]    timeout_status;

  int num_checks = 0;
  int num_errors = 0;
  logic [NS-1:0] en_seen;

  image_stage_sequencer #(
    .NUM_STAGES    (NS),
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .IDX_W         (2),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .stage_mask      (stage_mask),
    .abort           (abort),
    .pause           (pause),
    .stage_enable    (stage_enable),
    .stage_done      (stage_done),
    .stage_wren      (stage_wren),
    .stage_address   (stage_address),
    .stage_data_write(stage_data_write),
    .mem_wren        (mem_wren),
    .mem_address     (mem_address),
    .mem_data_write  (mem_data_write),
    .busy            (busy),
    .sequence_done   (sequence_done),
    .current_stage   (current_stage),
    .timeout_status  (timeout_status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    num_checks++;
    assert (obs === exp) else begin
      num_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n          = 1'b0;
    start            = 1'b0;
    stage_mask       = '0;
    abort            = 1'b0;
    pause            = 1'b0;
    stage_done       = '0;
    stage_wren       = '1;
    stage_address    = '1;
    stage_data_write = '1;
    en_seen          = '0;

    step(); step();
    check("rst_enable", 64'(stage_enable), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_seq_done", 64'(sequence_done), 0);
    check("rst_cur_stage", 64'(current_stage), 0);
    check("rst_timeout", 64'(timeout_status), 0);
    check("rst_mem_wren", 64'(mem_wren), 0);
    check("rst_mem_addr", 64'(mem_address), 0);
    stage_wren       = '0;
    stage_address    = '0;
    stage_data_write = '0;
    reset_n          = 1'b1;
    step();

    start = 1'b1; stage_mask = 4'b0101;
    step();
    start = 1'b0; stage_mask = '0;
    check("t1_select_busy", 64'(busy), 1);
    check("t1_select_en", 64'(stage_enable), 0);
    step();
    for (int i = 0; i < 10; i++) begin
      check("t1_s0_en", 64'(stage_enable), 4'b0001);
      en_seen |= stage_enable;
      start      = (i == 3);
      stage_mask = (i == 3) ? 4'b1000 : 4'b0000;
      stage_done = (i == 9) ? 4'b0001 : 4'b0000;
      step();
    end
    start = 1'b0; stage_mask = '0; stage_done = '0;
    check("t1_release_en", 64'(stage_enable), 0);
    check("t1_release_busy", 64'(busy), 1);
    step();
    check("t1_select2_en", 64'(stage_enable), 0);
    step();
    check("t1_s2_en0", 64'(stage_enable), 4'b0100);
    check("t1_s2_cur", 64'(current_stage), 2);
    stage_wren = 4'b0101;
    stage_address[0*AW +: AW]    = 18'd12345;
    stage_address[2*AW +: AW]    = 18'd79041;
    stage_data_write[0*DW +: DW] = 32'hDEAD_BEEF;
    stage_data_write[2*DW +: DW] = 32'd1;
    #1;
    check("mux_wren", 64'(mem_wren), 1);
    check("mux_addr", 64'(mem_address), 79041);
    check("mux_data", 64'(mem_data_write), 1);
    for (int i = 0; i < 10; i++) begin
      check("t1_s2_en", 64'(stage_enable), 4'b0100);
      en_seen |= stage_enable;
      stage_done = (i == 9) ? 4'b0100 : 4'b1011;
      step();
    end
    stage_done = '0;
    check("t1_release2_en", 64'(stage_enable), 0);
    check("mux_gated_wren", 64'(mem_wren), 0);
    check("mux_gated_addr", 64'(mem_address), 0);
    step();
    check("t1_select3_seq", 64'(sequence_done), 0);
    check("t1_select3_busy", 64'(busy), 1);
    step();
    check("t1_done_seq", 64'(sequence_done), 1);
    check("t1_done_busy", 64'(busy), 0);
    step();
    check("t1_idle_seq", 64'(sequence_done), 0);
    check("t1_en_seen", 64'(en_seen), 4'b0101);
    stage_wren = '0; stage_address = '0; stage_data_write = '0;

    start = 1'b1; stage_mask = '0;
    step();
    start = 1'b0;
    check("t2_seq", 64'(sequence_done), 1);
    check("t2_busy", 64'(busy), 0);
    check("t2_en", 64'(stage_enable), 0);
    step();
    check("t2_seq_after", 64'(sequence_done), 0);
    check("t2_busy_after", 64'(busy), 0);

    start = 1'b1; stage_mask = 4'b0001;
    step();
    start = 1'b0; stage_mask = '0;
    step();
    check("t3_run_en", 64'(stage_enable), 4'b0001);
    stage_done = 4'b0001; pause = 1'b1;
    stage_wren = 4'b0001; stage_address[0*AW +: AW] = 18'h2A5A5;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_pause_en", 64'(stage_enable), 4'b0001);
      check("t3_pause_busy", 64'(busy), 1);
      check("t3_pause_mux_wren", 64'(mem_wren), 1);
      check("t3_pause_mux_addr", 64'(mem_address), 18'h2A5A5);
    end
    pause = 1'b0;
    step();
    check("t3_release_en", 64'(stage_enable), 0);
    stage_done = '0; stage_wren = '0; stage_address = '0;
    step(); step();
    check("t3_done_seq", 64'(sequence_done), 1);
    step();

    start = 1'b1; stage_mask = 4'b0010;
    step();
    start = 1'b0; stage_mask = '0;
    step();
    check("t4_run_en", 64'(stage_enable), 4'b0010);
    check("t4_run_cur", 64'(current_stage), 1);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4_abort_en", 64'(stage_enable), 0);
    check("t4_abort_busy", 64'(busy), 0);
    check("t4_abort_seq", 64'(sequence_done), 0);
    step();
    check("t4_abort_seq2", 64'(sequence_done), 0);
    start = 1'b1; stage_mask = 4'b0010;
    step();
    start = 1'b0; stage_mask = '0;
    step();
    check("t4_rerun_en", 64'(stage_enable), 4'b0010);
    stage_done = 4'b0010;
    step();
    stage_done = '0;
    check("t4_rerun_release", 64'(stage_enable), 0);
    step(); step();
    check("t4_rerun_seq", 64'(sequence_done), 1);
    step();

    start = 1'b1; stage_mask = 4'b0001;
    step();
    start = 1'b0; stage_mask = '0;
    step();
    pause = 1'b1; abort = 1'b1;
    step();
    pause = 1'b0; abort = 1'b0;
    check("t5_abort_pause_en", 64'(stage_enable), 0);
    check("t5_abort_pause_busy", 64'(busy), 0);
    step();
    check("t5_abort_pause_seq", 64'(sequence_done), 0);

    start = 1'b1; stage_mask = 4'b0100;
    step();
    start = 1'b0; stage_mask = '0;
    step();
    check("t6_run_en", 64'(stage_enable), 4'b0100);
    reset_n = 1'b0;
    step();
    check("t6_rst_en", 64'(stage_enable), 0);
    check("t6_rst_busy", 64'(busy), 0);
    check("t6_rst_cur", 64'(current_stage), 0);
    reset_n = 1'b1;
    step();

`ifdef IMAGE_STAGE_SEQUENCER_TIMEOUT_EN
    start = 1'b1; stage_mask = 4'b0011;
    step();
    start = 1'b0; stage_mask = '0;
    step();
    for (int i = 0; i < 20; i++) begin
      check("t7_wd_en", 64'(stage_enable), 4'b0001);
      step();
    end
    check("t7_wd_release", 64'(stage_enable), 0);
    check("t7_wd_flag", 64'(timeout_status), 4'b0001);
    step();
    step();
    check("t7_next_stage", 64'(stage_enable), 4'b0010);
    stage_done = 4'b0010;
    step();
    stage_done = '0;
    step(); step();
    check("t7_seq", 64'(sequence_done), 1);
    check("t7_flag_kept", 64'(timeout_status), 4'b0001);
    step();
    start = 1'b1; stage_mask = 4'b0001;
    step();
    start = 1'b0; stage_mask = '0;
    check("t7_flag_cleared", 64'(timeout_status), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
`else
    check("t7_no_wd_flag", 64'(timeout_status), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
